// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory port,
// one outstanding access at a time. Define MEM_ARB_STARVE_GUARD_EN to bound data-port priority.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_GRANTS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  if (MAX_DATA_GRANTS < 1 || MAX_DATA_GRANTS > 15) begin : g_param_check
    $error("MAX_DATA_GRANTS must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port, 0 = instruction port
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        any_req, sel_data, force_instr, cur_owner, req_act, gnt_act, rsp_act;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_instr = instr_req_i && (starve_q == 4'(MAX_DATA_GRANTS));

  always_comb begin
    starve_d = starve_q;
    if (data_gnt_o) starve_d = instr_req_i ? starve_q + 4'd1 : 4'd0;
    else if (instr_gnt_o) starve_d = 4'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`else
  assign force_instr = 1'b0;
`endif

  always_comb begin
    any_req   = instr_req_i | data_req_i;
    sel_data  = data_req_i & ~force_instr;
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_act   = 1'b0;
    cur_owner = owner_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Selection is combinational so the request leaves in the same cycle.
          req_act   = 1'b1;
          cur_owner = sel_data;
          owner_d   = sel_data;
          we_d      = sel_data ? data_we_i    : 1'b0;
          be_d      = sel_data ? data_be_i    : 4'hF;
          addr_d    = sel_data ? data_addr_i  : instr_addr_i;
          wdata_d   = sel_data ? data_wdata_i : 32'd0;
          state_d   = mem_gnt_i ? WAIT : REQ;
        end
      end
      REQ: begin
        req_act = 1'b1;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) req_act = 1'b0;
  end

  assign gnt_act        = mem_gnt_i & req_act;
  assign rsp_act        = (state_q == WAIT) & mem_rvalid_i & ~rst_i;
  assign instr_gnt_o    = gnt_act & ~cur_owner;
  assign data_gnt_o     = gnt_act & cur_owner;
  assign instr_rvalid_o = rsp_act & ~owner_q;
  assign data_rvalid_o  = rsp_act & owner_q;
  assign rdata_o        = rst_i ? 32'd0 : mem_rdata_i;
  assign mem_req_o      = req_act;
  // Request fields come from the captured copy, so they hold even if the requester lets go.
  assign mem_we_o       = req_act ? we_d    : 1'b0;
  assign mem_be_o       = req_act ? be_d    : 4'h0;
  assign mem_addr_o     = req_act ? addr_d  : 32'd0;
  assign mem_wdata_o    = req_act ? wdata_d : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    be_q    <= be_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule
